// File: rtl/seq_shift_alu.sv
// rtl/seq_shift_alu.sv - multi-cycle shift/rotate ALU, one bit position per clock
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             request, sampled only in IDLE or DONE
//   operand_a         source operand, captured on accept
//   alu_op            operation code, captured on accept
//   shift_amt         bit positions, captured on accept, clamped to WIDTH
//   busy              high while shifting
//   done              one-cycle pulse when result/flags are valid
//   result            registered result, held until next accept
//   shift_overflow    sticky OR of all bits shifted out
//   zero              registered result == 0
module seq_shift_alu #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [3:0]       alu_op,
    input  logic [AMT_W-1:0] shift_amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             shift_overflow,
    output logic             zero
);

    localparam logic [3:0] OP_PUR = 4'd0;
    localparam logic [3:0] OP_SHL = 4'd1;
    localparam logic [3:0] OP_SHR = 4'd2;
    localparam logic [3:0] OP_UNC = 4'd3;
    localparam logic [3:0] OP_ROL = 4'd4;
    localparam logic [3:0] OP_ROR = 4'd5;
    localparam logic [3:0] OP_ASR = 4'd6;

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       op_r;
    logic [AMT_W-1:0] count;

    logic             accept;
    logic             is_shift_op;
    logic [AMT_W-1:0] amt_eff;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] step_val;
    logic             step_out;

    // Only IDLE and DONE accept; DONE accepting gives back-to-back operation.
    assign accept = start && (state == ST_IDLE || state == ST_DONE);

    always_comb begin
        is_shift_op = (alu_op == OP_SHL) || (alu_op == OP_SHR) ||
                      (alu_op == OP_ROL) || (alu_op == OP_ROR) ||
                      (alu_op == OP_ASR);
        amt_eff     = (shift_amt > AMT_MAX) ? AMT_MAX : shift_amt;
        load_val    = (alu_op == OP_UNC) ? WIDTH'(1) : operand_a;
    end

    // One bit position of the captured operation applied to the result register.
    always_comb begin
        step_val = result;
        step_out = 1'b0;
        case (op_r)
            OP_SHL: begin
                step_val = {result[WIDTH-2:0], 1'b0};
                step_out = result[WIDTH-1];
            end
            OP_SHR: begin
                step_val = {1'b0, result[WIDTH-1:1]};
                step_out = result[0];
            end
            OP_ROL: step_val = {result[WIDTH-2:0], result[WIDTH-1]};
            OP_ROR: step_val = {result[0], result[WIDTH-1:1]};
            OP_ASR: begin
                step_val = {result[WIDTH-1], result[WIDTH-1:1]};
                step_out = result[0];
            end
            default: begin
                step_val = result;
                step_out = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            op_r           <= OP_PUR;
            count          <= '0;
            result         <= '0;
            zero           <= 1'b1;
            shift_overflow <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else if (accept) begin
            op_r           <= alu_op;
            result         <= load_val;
            zero           <= (load_val == '0);
            shift_overflow <= 1'b0;
            count          <= amt_eff;
            if (is_shift_op && amt_eff != '0) begin
                state <= ST_SHIFT;
                busy  <= 1'b1;
                done  <= 1'b0;
            end else begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end
        end else begin
            case (state)
                ST_SHIFT: begin
                    result         <= step_val;
                    zero           <= (step_val == '0);
                    shift_overflow <= shift_overflow | step_out;
                    count          <= count - AMT_ONE;
                    if (count == AMT_ONE) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_alu.sv
// tb/tb_seq_shift_alu.sv - directed self-checking bench for seq_shift_alu
module tb_seq_shift_alu;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] operand_a;
    logic [3:0] alu_op;
    logic [3:0] shift_amt;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       shift_overflow;
    logic       zero;

    int n_tests;
    int n_fail;

    seq_shift_alu #(.WIDTH(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .operand_a      (operand_a),
        .alu_op         (alu_op),
        .shift_amt      (shift_amt),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .shift_overflow (shift_overflow),
        .zero           (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op (caller sits 1 time unit after an edge, DUT in IDLE/DONE),
    // then wait for done and check latency, busy duration, result and flags.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [3:0] amt, input logic [7:0] exp_res,
                          input logic exp_ovf, input int exp_lat);
        int lat;
        int busy_cnt;
        start     = 1'b1;
        alu_op    = op;
        operand_a = a;
        shift_amt = amt;
        tick();
        start    = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy_cycles"}, busy_cnt, exp_lat - 1);
        check({tag, " busy_at_done"}, busy, 1'b0);
        check({tag, " result"}, result, exp_res);
        check({tag, " overflow"}, shift_overflow, exp_ovf);
        check({tag, " zero"}, zero, exp_res == 8'h00);
    endtask

    initial begin
        int lat;
        int seen_done;
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        operand_a = 8'h00;
        alu_op    = 4'd0;
        shift_amt = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst result", result, 8'h00);
        check("rst zero", zero, 1'b1);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst overflow", shift_overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_op("shl81_1", 4'd1, 8'h81, 4'd1, 8'h02, 1'b1, 2);
        run_op("shrF0_4", 4'd2, 8'hF0, 4'd4, 8'h0F, 1'b0, 5);
        run_op("shrF0_5", 4'd2, 8'hF0, 4'd5, 8'h07, 1'b1, 6);
        run_op("rol81_3", 4'd4, 8'h81, 4'd3, 8'h0C, 1'b0, 4);
        run_op("ror01_8", 4'd5, 8'h01, 4'd8, 8'h01, 1'b0, 9);
        run_op("asr80_15", 4'd6, 8'h80, 4'd15, 8'hFF, 1'b1, 9);
        run_op("shl80_9", 4'd1, 8'h80, 4'd9, 8'h00, 1'b1, 9);
        run_op("shr0F_8", 4'd2, 8'h0F, 4'd8, 8'h00, 1'b1, 9);
        run_op("asr40_2", 4'd6, 8'h41, 4'd2, 8'h10, 1'b1, 3);
        run_op("shl_amt0", 4'd1, 8'hA5, 4'd0, 8'hA5, 1'b0, 1);
        run_op("pur5A_7", 4'd0, 8'h5A, 4'd7, 8'h5A, 1'b0, 1);
        run_op("uncAA", 4'd3, 8'hAA, 4'd3, 8'h01, 1'b0, 1);
        run_op("op12_3C", 4'd12, 8'h3C, 4'd5, 8'h3C, 1'b0, 1);
        run_op("pur00", 4'd0, 8'h00, 4'd0, 8'h00, 1'b0, 1);

        // Back-to-back PUR starts: a fresh result every edge, done held high.
        tick();
        start  = 1'b1;
        alu_op = 4'd0;
        for (int i = 0; i < 3; i++) begin
            operand_a = 8'h11 + 8'(i * 8'h22);
            tick();
            check($sformatf("b2b%0d done", i), done, 1'b1);
            check($sformatf("b2b%0d result", i), result, 8'h11 + 8'(i * 8'h22));
        end
        start = 1'b0;
        tick();
        check("b2b done drops", done, 1'b0);

        // Inputs toggled mid-shift must not disturb the operation in flight.
        start     = 1'b1;
        alu_op    = 4'd1;
        operand_a = 8'h01;
        shift_amt = 4'd6;
        tick();
        start = 1'b0;
        lat   = 1;
        for (int i = 0; i < 3; i++) begin
            start     = ~start;
            operand_a = 8'hFF;
            alu_op    = 4'd0;
            shift_amt = 4'd1;
            tick();
            lat++;
        end
        start = 1'b0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        check("toggle latency", lat, 7);
        check("toggle result", result, 8'h40);
        check("toggle overflow", shift_overflow, 1'b0);

        // Reset pulse mid-SHR aborts immediately, no done pulse afterwards.
        tick();
        start     = 1'b1;
        alu_op    = 4'd2;
        operand_a = 8'hFF;
        shift_amt = 4'd8;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre-abort busy", busy, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort result", result, 8'h00);
        check("abort zero", zero, 1'b1);
        check("abort busy", busy, 1'b0);
        check("abort overflow", shift_overflow, 1'b0);
        check("abort done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) seen_done = 1;
        end
        check("abort no done", seen_done, 0);
        run_op("post_rst_ror", 4'd5, 8'h03, 4'd1, 8'h81, 1'b0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_shift_alu.md
# seq_shift_alu

Multi-cycle, width-parametrised successor to the CPU's single-bit move/shift ALU. Accepts an operand, an operation and a shift amount under a start/done handshake, then performs shifts and rotates one bit position per clock. It reports the result, a sticky shifted-out flag and a zero flag. It sits in the CPU datapath between the register file read port and the write-back mux; the control unit stalls on `busy`.

## Interface
- `WIDTH`, default 8: operand/result width, minimum 2.
- `AMT_W`, default `$clog2(WIDTH+1)`: width of `shift_amt`.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled only when accepting (IDLE or DONE state).
- `operand_a`  in  WIDTH  source operand, captured on the accepted start.
- `alu_op`  in  4  operation code, captured on the accepted start.
- `shift_amt`  in  AMT_W  number of bit positions, captured on the accepted start.
- `busy`  out  1  high in the SHIFT state.
- `done`  out  1  one-cycle pulse; result and flags are valid.
- `result`  out  WIDTH  registered result, held until the next accepted start.
- `shift_overflow`  out  1  OR of every bit shifted out during the operation.
- `zero`  out  1  `result == 0`, registered alongside `result`.

## Operation
- Op codes:
  - 0 PUR: `result = operand_a`.
  - 1 SHL: logical left, zero fill.
  - 2 SHR: logical right, zero fill.
  - 3 UNC: `result = 1`, i.e. TRUE.
  - 4 ROL: rotate left.
  - 5 ROR: rotate right.
  - 6 ASR: arithmetic right, MSB fill.
  - 7–15: NOP, treated as PUR.
- States:
  - IDLE → on start: load regs; go to SHIFT if the op is a shift/rotate and the clamped amount is > 0, else DONE.
  - SHIFT: each edge moves one bit and decrements the count; count 1 → DONE.
  - DONE → accepts start exactly as IDLE does (back-to-back operation); else IDLE.
- Amount clamping: `shift_amt > WIDTH` is clamped to WIDTH.
  - SHL/SHR by WIDTH gives 0.
  - ASR by WIDTH gives all copies of the sign bit.
  - ROL/ROR by WIDTH returns the operand unchanged.
- Non-shift ops (PUR, UNC, NOP) ignore `shift_amt`.
- `shift_overflow`:
  - Cleared on accept.
  - SHL ORs in the outgoing MSB; SHR/ASR OR in the outgoing LSB.
  - Stays 0 for rotates, PUR, UNC and NOP.
- `zero` is recomputed from the result register every cycle.
- `start` during SHIFT is ignored: not queued, no effect on the operation in flight.
- Captured operands are independent of input changes after acceptance.

## Timing
- Reset (async assert, sync release): state IDLE, `result=0`, `zero=1`, `shift_overflow=0`, `busy=0`, `done=0`.
- Start accepted at edge k with effective amount n:
  - `done` is high in the cycle following edge k+n.
  - Latency is n+1 edges; n=0 and non-shift ops complete in 1 edge.
- `busy` is high from after edge k through edge k+n−1 (n cycles); it is never high together with `done`.
- `result`/`shift_overflow` show intermediate values while `busy`. They are valid only when `done` is high and are held stable thereafter until the next accept.
- Back-to-back: a start in the DONE cycle is accepted at that edge; `done` drops unless the new op completes in 1 edge, in which case `done` stays high for a second cycle.
- Reset mid-SHIFT aborts immediately to the reset values; no `done` pulse is produced.

## Test plan
- After reset: `result=0`, `zero=1`, `busy=0`, `done=0`. SHL `0x81` amt 1 → `done` 2 edges after accept, `result=0x02`, `shift_overflow=1`, `zero=0`.
- SHR `0xF0` amt 4 → `0x0F`, overflow 0, `busy` for 4 cycles. Then SHR `0xF0` amt 5 → `0x07`, overflow 1.
- ROL `0x81` amt 3 → `0x0C`, overflow 0. ROR `0x01` amt 8 → `0x01`. ASR `0x80` amt 15 (clamped to 8) → `0xFF`, overflow 1, latency 9.
- PUR `0x5A` amt 7 → `0x5A` after 1 edge. UNC → `0x01`. Op 12 → pass-through. Back-to-back PUR starts: a fresh result each edge, `done` held high.
- SHL `0x01` amt 6 with `start`/`operand_a` toggled mid-shift → unaffected `0x40`. Then `rst_n` pulsed low mid-SHR → immediate reset values, no `done`, next op correct.
